// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher (AES-128/192/256 via Nk): one inverse round per clock,
// full key schedule captured at accept, valid/ready on both sides with output backpressure.
module aes_decrypt_iterative #(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      data_in,
  input  logic [Nk*32-1:0]  key_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      data_out,
  output logic              busy
);

  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned CW = 4;

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_decrypt_iterative: Nk must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;
  typedef logic [Nr:0][127:0] rk_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = ginv(x);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[8*(15-(4*c+r)) +: 8];
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                                 gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  function automatic rk_t key_expand(input logic [Nk*32-1:0] key);
    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_t         rk;
    rc = 8'h01;
    for (int i = 0; i < int'(NW); i++) begin
      if (i < int'(Nk)) begin
        w[i] = key[(Nk*32-1-32*i) -: 32];
      end else begin
        t = w[i-1];
        if (i % int'(Nk) == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (Nk > 6 && i % int'(Nk) == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-int'(Nk)] ^ t;
      end
    end
    for (int r = 0; r <= int'(Nr); r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  state_e          state_q, state_d;
  logic [127:0]    blk_q, blk_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    data_out_q, data_out_d;
  rk_t             rk_q, rk_d;
  rk_t             rk_new;
  logic [127:0]    rnd;

  assign rk_new    = key_expand(key_in);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND) || (state_q == FINAL);
  assign data_out  = data_out_q;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    cnt_d      = cnt_q;
    rk_d       = rk_q;
    data_out_d = data_out_q;
    rnd        = inv_sub(inv_shift(blk_q));
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          rk_d    = rk_new;
          blk_d   = data_in ^ rk_new[Nr];
          cnt_d   = CW'(Nr - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = inv_mix(rnd ^ rk_q[cnt_q]);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINAL;
      end
      FINAL: begin
        blk_d      = rnd ^ rk_q[0];
        data_out_d = rnd ^ rk_q[0];
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      blk_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  // Round keys are only read after an accept has loaded them, so they need no reset.
  always_ff @(posedge clk) begin
    rk_q <= rk_d;
  end

endmodule

// File: doc/aes_decrypt_iterative.md
# aes_decrypt_iterative

Iterative, parametrised AES inverse cipher (FIPS-197) that decrypts one 128-bit block per transaction, executing one inverse round per clock instead of unrolling all rounds combinationally. It supports AES-128/192/256 via Nk and adds valid/ready handshakes with output backpressure. It sits between the block-level input buffer and the plaintext sink, and reuses the team's existing InvShiftRows, InvSubBytes, InvMixColumns and KeyExpansion primitives.

## Interface
- Nk, default 4: key length in 32-bit words; legal values 4, 6, 8 (any other value is an elaboration error).
- Nr, default Nk+6: number of rounds; never overridden independently of Nk.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in/key_in are valid.
- in_ready  output  1  block can accept a transaction.
- data_in  input  128  ciphertext, byte 0 at bits [127:120].
- key_in  input  Nk*32  cipher key, word 0 at MSBs.
- out_valid  output  1  data_out holds a finished plaintext.
- out_ready  input  1  sink accepts data_out.
- data_out  output  128  plaintext, same byte order as data_in.
- busy  output  1  high in ROUND and FINAL.

## Operation
- States: IDLE, ROUND, FINAL, DONE. Reset → IDLE.
- Accept: in_valid && in_ready at an edge. In IDLE, in_ready = !rst; in all other states in_ready = 0.
- On accept:
  - The full key schedule (4*(Nr+1) words) is expanded combinationally from key_in and registered.
  - state ← data_in ^ rk[Nr].
  - round counter ← Nr-1.
  - Go to ROUND. key_in and data_in are not sampled again.
- ROUND, one edge per round:
  - state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]).
  - cnt decrements.
  - When cnt==1 is processed, go to FINAL.
  - Nr-1 ROUND cycles in total.
- FINAL:
  - state ← InvSubBytes(InvShiftRows(state)) ^ rk[0].
  - data_out ← that value.
  - Go to DONE.
- DONE:
  - out_valid=1.
  - data_out is held stable until out_valid && out_ready.
  - On that edge, go to IDLE.
- in_valid while not in IDLE is ignored; the source must hold it.
- The round-key index is always within 0..Nr; the counter never wraps.
- Reset mid-operation (any state): next edge → IDLE. The in-flight block is discarded and no out_valid is produced for it.

## Timing
- Reset values:
  - out_valid=0, data_out=0, busy=0.
  - in_ready=0 while rst is high, 1 in the first cycle after rst deasserts.
- Latency: accept at edge E0, ROUND on E1..E(Nr-1), FINAL on E(Nr). out_valid is high from the cycle after E(Nr): Nr cycles after accept (10/12/14 for Nk=4/6/8).
- The output handshake at edge Ek makes in_ready=1 in the following cycle. Minimum transaction spacing is Nr+2 cycles with out_ready tied high.
- out_valid never drops without a completed handshake, except on rst.
- in_ready and out_valid are never high in the same cycle.
- rst and in_valid high together: reset wins and no accept occurs.

## Test plan
- Nk=4, key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 → out_valid exactly 10 cycles after accept, data_out 00112233445566778899aabbccddeeff.
- Nk=6, key 000102…1617, data_in dda97ca4864cdfe06eaf70a0ec0d7191 → after 12 cycles, data_out 00112233445566778899aabbccddeeff.
- Nk=8, key 000102…1e1f, data_in 8ea2b7ca516745bfeafc49904b496089 → after 14 cycles, data_out 00112233445566778899aabbccddeeff.
- Backpressure (Nk=4 vector): out_ready=0 for 5 cycles after out_valid → data_out and out_valid stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE and in_ready=1 the next cycle.
- Back-to-back (Nk=4): two different key/ciphertext pairs, in_valid held, out_ready=1 → both plaintexts correct and in order, second accept Nr+2 cycles after the first.
- rst pulsed for one cycle during ROUND (cycle 4 after accept) → outputs return to reset values, no out_valid for the aborted block, and a subsequent Nk=4 vector decrypts correctly.
